// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO controller slice: sizing helpers, defaults and pointer type.
package fifo_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    localparam int FIFO_DEPTH_DEF  = 8;
    localparam int DATA_W          = 8;
    localparam int FIFO_ADDR_W_DEF = clog2(FIFO_DEPTH_DEF);

    // One extra bit beyond the address distinguishes full from empty.
    typedef logic [FIFO_ADDR_W_DEF:0] ptr_t;

endpackage

// File: rtl/fifo_mem_ctrl_if.sv
// Producer/consumer handshake plus memory sequencing and status signals of the FIFO controller.
interface fifo_mem_ctrl_if #(
    parameter int ADDR_W = 3
) ();
    logic              push_i;
    logic              pop_i;
    logic              flush_i;
    logic              mem_wr_en_o;
    logic [ADDR_W-1:0] mem_wr_addr_o;
    logic              mem_rd_en_o;
    logic [ADDR_W-1:0] mem_rd_addr_o;
    logic              rd_valid_o;
    logic              full_o;
    logic              empty_o;
    logic              almost_full_o;
    logic              almost_empty_o;
    logic [ADDR_W:0]   count_o;
    logic              overflow_o;
    logic              underflow_o;

    modport master (
        output push_i, pop_i, flush_i,
        input  mem_wr_en_o, mem_wr_addr_o, mem_rd_en_o, mem_rd_addr_o, rd_valid_o,
        input  full_o, empty_o, almost_full_o, almost_empty_o, count_o,
        input  overflow_o, underflow_o
    );

    modport slave (
        input  push_i, pop_i, flush_i,
        output mem_wr_en_o, mem_wr_addr_o, mem_rd_en_o, mem_rd_addr_o, rd_valid_o,
        output full_o, empty_o, almost_full_o, almost_empty_o, count_o,
        output overflow_o, underflow_o
    );
endinterface

// File: rtl/fifo_ptr.sv
// Wrapping (ADDR_W+1)-bit FIFO pointer; exposes its next-state value and the memory address bits.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int ADDR_W = FIFO_ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_i,
    input  logic              clr_i,
    output logic [ADDR_W:0]   ptr_d_o,
    output logic [ADDR_W-1:0] addr_o
);

    logic [ADDR_W:0] ptr_q;
    logic [ADDR_W:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_d_o = ptr_d;
    assign addr_o  = ptr_q[ADDR_W-1:0];

endmodule

// File: rtl/fifo_mem_ctrl.sv
// Circular-buffer controller for the dual-port memory: pointers, enables, registered status, sticky errors.
module fifo_mem_ctrl
    import fifo_pkg::*;
#(
    parameter int DEPTH    = FIFO_DEPTH_DEF,
    parameter int ADDR_W   = clog2(DEPTH),
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2
) (
    input  logic            clk,
    input  logic            rst,
    fifo_mem_ctrl_if.slave  bus
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);

    logic            pop_acc;
    logic            push_acc;
    logic [ADDR_W:0] wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_d;
    logic [ADDR_W:0] count_d;

    logic [ADDR_W:0] count_q;
    logic            full_q;
    logic            empty_q;
    logic            af_q;
    logic            ae_q;
    logic            rd_valid_q;
    logic            overflow_q;
    logic            underflow_q;

    // A pop frees the slot a simultaneous push needs, so push may proceed while full.
    assign pop_acc  = bus.pop_i && !empty_q && !bus.flush_i;
    assign push_acc = bus.push_i && (!full_q || pop_acc) && !bus.flush_i;

    fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (push_acc),
        .clr_i   (bus.flush_i),
        .ptr_d_o (wr_ptr_d),
        .addr_o  (bus.mem_wr_addr_o)
    );

    fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (pop_acc),
        .clr_i   (bus.flush_i),
        .ptr_d_o (rd_ptr_d),
        .addr_o  (bus.mem_rd_addr_o)
    );

    assign count_d = wr_ptr_d - rd_ptr_d;

    // Status is derived from next-state pointers so it is glitch-free and aligned with the pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            af_q        <= 1'b0;
            ae_q        <= 1'b1;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            full_q      <= (count_d == DEPTH_C);
            empty_q     <= (count_d == '0);
            af_q        <= (count_d >= AF_C);
            ae_q        <= (count_d <= AE_C);
            rd_valid_q  <= pop_acc;
            overflow_q  <= overflow_q  | (bus.push_i && !push_acc && !bus.flush_i);
            underflow_q <= underflow_q | (bus.pop_i  && !pop_acc  && !bus.flush_i);
        end
    end

    assign bus.mem_wr_en_o    = push_acc;
    assign bus.mem_rd_en_o    = pop_acc;
    assign bus.rd_valid_o     = rd_valid_q;
    assign bus.full_o         = full_q;
    assign bus.empty_o        = empty_q;
    assign bus.almost_full_o  = af_q;
    assign bus.almost_empty_o = ae_q;
    assign bus.count_o        = count_q;
    assign bus.overflow_o     = overflow_q;
    assign bus.underflow_o    = underflow_q;

endmodule

// File: tb/tb_fifo_mem_ctrl.sv
// Bench for fifo_mem_ctrl: queue-based reference model, per-cycle compare, directed scenarios.
module tb_fifo_mem_ctrl;
    import fifo_pkg::*;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int AF_LVL = 6;
    localparam int AE_LVL = 2;

    logic clk;
    logic rst;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] data_o;
    logic [DATA_W-1:0] mem [DEPTH];

    int n_chk;
    int n_fail;
    bit started;
    int last_wr_en;
    int last_rd_en;

    // Reference model state
    logic [DATA_W-1:0] q[$];
    int m_ov, m_un, m_rv, m_wa, m_ra;
    logic [DATA_W-1:0] m_data;

    fifo_mem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    fifo_mem_ctrl #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .AF_LEVEL (AF_LVL),
        .AE_LEVEL (AE_LVL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the dual-port memory: registered read, read-before-write on collision.
    always @(posedge clk) begin
        if (bus.mem_wr_en_o) mem[bus.mem_wr_addr_o] <= wdata;
        if (bus.mem_rd_en_o) data_o <= mem[bus.mem_rd_addr_o];
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model update on every rising edge
    initial begin
        m_ov = 0; m_un = 0; m_rv = 0; m_wa = 0; m_ra = 0; m_data = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                q.delete();
                m_ov = 0; m_un = 0; m_rv = 0; m_wa = 0; m_ra = 0;
            end else if (bus.flush_i) begin
                q.delete();
                m_rv = 0; m_wa = 0; m_ra = 0;
            end else begin
                bit pa, wa;
                pa = bus.pop_i && (q.size() > 0);
                wa = bus.push_i && ((q.size() < DEPTH) || pa);
                if (bus.pop_i && !pa) m_un = 1;
                if (bus.push_i && !wa) m_ov = 1;
                m_rv = pa ? 1 : 0;
                if (pa) begin
                    m_data = q.pop_front();
                    m_ra = (m_ra + 1) % DEPTH;
                end
                if (wa) begin
                    q.push_back(wdata);
                    m_wa = (m_wa + 1) % DEPTH;
                end
            end
        end
    end

    // Compare on every falling edge once out of reset
    initial begin
        forever begin
            @(negedge clk);
            if (started && !rst) begin
                int cnt;
                int e_pop, e_push;
                cnt    = q.size();
                e_pop  = (bus.pop_i && !bus.flush_i && cnt > 0) ? 1 : 0;
                e_push = (bus.push_i && !bus.flush_i && (cnt < DEPTH || e_pop == 1)) ? 1 : 0;
                last_wr_en = int'(bus.mem_wr_en_o);
                last_rd_en = int'(bus.mem_rd_en_o);
                chk("count",        int'(bus.count_o),        cnt);
                chk("full",         int'(bus.full_o),         (cnt == DEPTH) ? 1 : 0);
                chk("empty",        int'(bus.empty_o),        (cnt == 0) ? 1 : 0);
                chk("almost_full",  int'(bus.almost_full_o),  (cnt >= AF_LVL) ? 1 : 0);
                chk("almost_empty", int'(bus.almost_empty_o), (cnt <= AE_LVL) ? 1 : 0);
                chk("overflow",     int'(bus.overflow_o),     m_ov);
                chk("underflow",    int'(bus.underflow_o),    m_un);
                chk("rd_valid",     int'(bus.rd_valid_o),     m_rv);
                chk("wr_en",        int'(bus.mem_wr_en_o),    e_push);
                chk("rd_en",        int'(bus.mem_rd_en_o),    e_pop);
                chk("wr_addr",      int'(bus.mem_wr_addr_o),  m_wa);
                chk("rd_addr",      int'(bus.mem_rd_addr_o),  m_ra);
                if (m_rv == 1) chk("data", int'(data_o), int'(m_data));
            end
        end
    end

    // Drive inputs just after an edge, let them be sampled at the next edge, return 1 time unit later.
    task automatic step(input bit p, input bit r, input bit f, input logic [DATA_W-1:0] d);
        bus.push_i  = p;
        bus.pop_i   = r;
        bus.flush_i = f;
        wdata       = d;
        @(posedge clk);
        #1;
        bus.push_i  = 1'b0;
        bus.pop_i   = 1'b0;
        bus.flush_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_chk = 0; n_fail = 0; started = 0;
        last_wr_en = 0; last_rd_en = 0;
        rst = 1'b1;
        bus.push_i = 1'b0; bus.pop_i = 1'b0; bus.flush_i = 1'b0;
        wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        started = 1;

        // 1: reset state
        chk("t1_empty",   int'(bus.empty_o), 1);
        chk("t1_ae",      int'(bus.almost_empty_o), 1);
        chk("t1_count",   int'(bus.count_o), 0);
        chk("t1_wr_addr", int'(bus.mem_wr_addr_o), 0);
        chk("t1_rd_addr", int'(bus.mem_rd_addr_o), 0);
        chk("t1_rd_valid",int'(bus.rd_valid_o), 0);

        // 2: fill to full, then overflow
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0, 8'(8'h10 + i));
            if (i == 4) chk("t2_af_at5", int'(bus.almost_full_o), 0);
            if (i == 5) chk("t2_af_at6", int'(bus.almost_full_o), 1);
        end
        chk("t2_full",  int'(bus.full_o), 1);
        chk("t2_count", int'(bus.count_o), 8);
        step(1, 0, 0, 8'h18);
        chk("t2_ovf_wr_en", last_wr_en, 0);
        chk("t2_overflow",  int'(bus.overflow_o), 1);
        chk("t2_ovf_count", int'(bus.count_o), 8);

        // 3: simultaneous push/pop while full, then drain
        step(1, 1, 0, 8'h55);
        chk("t3_wr_en",    last_wr_en, 1);
        chk("t3_rd_en",    last_rd_en, 1);
        chk("t3_count",    int'(bus.count_o), 8);
        chk("t3_rd_valid", int'(bus.rd_valid_o), 1);
        chk("t3_data",     int'(data_o), 8'h10);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 8'h00);
        chk("t3_last",     int'(data_o), 8'h55);
        chk("t3_empty",    int'(bus.empty_o), 1);

        // 4: underflow, then push+pop on empty
        step(0, 1, 0, 8'h00);
        chk("t4_rd_en",    last_rd_en, 0);
        chk("t4_underflow",int'(bus.underflow_o), 1);
        chk("t4_count",    int'(bus.count_o), 0);
        step(1, 1, 0, 8'hAA);
        chk("t4_wr_en",    last_wr_en, 1);
        chk("t4_rd_en2",   last_rd_en, 0);
        chk("t4_count1",   int'(bus.count_o), 1);
        chk("t4_uf_stick", int'(bus.underflow_o), 1);
        step(0, 1, 0, 8'h00);
        chk("t4_data",     int'(data_o), 8'hAA);

        // 5: interleaved traffic across pointer wrap
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 0, 8'(i));
            step(0, 1, 0, 8'h00);
            chk("t5_data", int'(data_o), i);
        end

        // 6: flush with push, sticky retained, then reset clears sticky
        for (int i = 0; i < 5; i++) step(1, 0, 0, 8'(8'h30 + i));
        chk("t6_count5",   int'(bus.count_o), 5);
        step(1, 0, 1, 8'h99);
        chk("t6_wr_en",    last_wr_en, 0);
        chk("t6_count",    int'(bus.count_o), 0);
        chk("t6_empty",    int'(bus.empty_o), 1);
        chk("t6_ovf",      int'(bus.overflow_o), 1);
        chk("t6_rd_addr",  int'(bus.mem_rd_addr_o), 0);

        // Reset mid-operation drops a pending read
        step(1, 0, 0, 8'h77);
        rst = 1'b1;
        step(0, 1, 0, 8'h00);
        rst = 1'b0;
        chk("t6_rst_rv",   int'(bus.rd_valid_o), 0);
        chk("t6_rst_ovf",  int'(bus.overflow_o), 0);
        chk("t6_rst_unf",  int'(bus.underflow_o), 0);
        chk("t6_rst_cnt",  int'(bus.count_o), 0);
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
